aes_pipe_ctrl: RTL and testbench
================================

AES_PIPE_CTRL -- requirements
Module: aes_pipe_ctrl

Interface
REQ-001 Parameter LAT, default 11: clock cycles from core_data_in to the matching core_data_out of the attached pipelined AES-128 core.
REQ-002 Parameter DEPTH, default 16: output FIFO entries; DEPTH >= LAT.
REQ-003 Parameter KEY_LAT, default 11: cycles the core's key expansion needs after core_key changes.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port in_valid / in_ready  in / out  1 / 1  plaintext handshake.
REQ-007 Port in_data  in  128  plaintext block.
REQ-008 Port key_valid / key_ready  in / out  1 / 1  new-key handshake.
REQ-009 Port key_in  in  128  cipher key.
REQ-010 Port out_valid / out_ready  out / in  1 / 1  ciphertext handshake.
REQ-011 Port out_data  out  128  ciphertext block.
REQ-012 Port core_data_in  out  128  registered block driven to the core.
REQ-013 Port core_key  out  128  registered key driven to the core.
REQ-014 Port core_data_out  in  128  core result.
REQ-015 Port busy  out  1  high when state != RUN or inflight != 0 or FIFO is non-empty.

Function
REQ-016 A transfer occurs only on a cycle where valid and ready are both high; data is sampled on that edge.
REQ-017 FSM states: KEYWAIT, RUN, DRAIN, SETTLE.
REQ-018 After reset the state is KEYWAIT; in_ready=0 and key_ready=1 in KEYWAIT.
REQ-019 KEYWAIT: a key transfer latches key_in into core_key, loads the settle counter with KEY_LAT, and moves to SETTLE.
REQ-020 SETTLE: in_ready=0 and key_ready=0; the counter decrements each cycle; at 1 the FSM goes to RUN.
REQ-021 RUN: key_ready=0; in_ready = (inflight + fifo_count < DEPTH); this credit rule guarantees no core result is ever dropped.
REQ-022 RUN with key_valid=1: the FSM goes to DRAIN next cycle; a same-cycle input transfer is still accepted.
REQ-023 DRAIN: in_ready=0; key_ready=1 only when inflight==0; a key transfer behaves as in REQ-019.
REQ-024 An input transfer registers in_data into core_data_in and sets bit 0 of a LAT-bit valid shift register that shifts every cycle.
REQ-025 When the MSB of the shift register is 1, core_data_out is written into the FIFO in that cycle.
REQ-026 inflight (0..LAT, clog2(LAT+1) bits) increments on an input transfer and decrements on a core write.
REQ-027 If an input transfer and a core write occur on the same cycle, inflight is unchanged.
REQ-028 FIFO is first-word-fall-through: out_valid = (fifo_count != 0) and out_data = head entry.
REQ-029 Simultaneous FIFO write and read: both take effect and fifo_count is unchanged; a read on a full FIFO in the same cycle as a write is legal.
REQ-030 FIFO read/write pointers wrap modulo DEPTH.
REQ-031 Output order equals input order; throughput is 1 block/cycle while out_ready=1.
REQ-032 The core is never stalled; core_data_in holds its last value when there is no transfer.

Reset
REQ-033 rst_n low, asynchronously: state=KEYWAIT, shift register=0, inflight=0, FIFO pointers/count=0, settle counter=0, core_key=0, core_data_in=0, out_valid=0, in_ready=0, key_ready=1, busy=1.
REQ-034 Reset mid-operation discards all in-flight and buffered blocks; no out_valid pulse occurs until a new key and new input are accepted.

Verification
REQ-035 Reset, key 000102..0f, KEY_LAT settle, plaintext 00112233445566778899aabbccddeeff -> out_valid exactly LAT+1 cycles after the input transfer, with out_data=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-036 20 back-to-back inputs with out_ready=0 -> in_ready falls after 16 accepts, the FIFO fills to 16, no loss; out_ready=1 then yields 20 in-order outputs.
REQ-037 key_valid asserted while 5 blocks are in flight -> in_ready=0 next cycle, key_ready=1 only after inflight=0; the 5 results use the old key and later blocks use the new key.
REQ-038 out_ready=1 with continuous input -> steady 1 block/cycle, with a FIFO write and read on the same cycle and count constant.
REQ-039 rst_n pulsed low mid-stream (inflight=7, fifo_count=3) -> all outputs reach reset values immediately and no stale block ever emerges.
REQ-040 FIFO pointer wrap: 40 blocks with random out_ready stalls -> outputs match a reference model exactly, in order.

Source files
------------

// File: rtl/aes_pipe_ctrl.sv
// Flow controller for a fixed-latency pipelined AES-128 core: key load/settle FSM,
// credit-based input admission, in-flight tracking and a FWFT result FIFO.
module aes_pipe_ctrl #(
    parameter int LAT     = 11,
    parameter int DEPTH   = 16,
    parameter int KEY_LAT = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [127:0] core_data_in,
    output logic [127:0] core_key,
    input  logic [127:0] core_data_out,
    output logic         busy
);

    localparam int IW = $clog2(LAT + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(KEY_LAT + 1);

    typedef enum logic [1:0] {KEYWAIT, RUN, DRAIN, SETTLE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   settle_cnt;
    logic [LAT-1:0]  vld_pipe;
    logic [IW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [127:0]    fifo_mem [DEPTH];
    logic [CW:0]     credit_used;
    logic            in_fire;
    logic            key_fire;
    logic            core_wr;
    logic            fifo_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    // Every admitted block already owns a FIFO slot, so the core never has to stall.
    assign credit_used = (CW+1)'(inflight) + (CW+1)'(fifo_count);
    assign in_fire     = in_valid & in_ready;
    assign key_fire    = key_valid & key_ready;
    assign core_wr     = vld_pipe[LAT-1];
    assign out_valid   = (fifo_count != '0);
    assign fifo_rd     = out_valid & out_ready;
    assign out_data    = fifo_mem[rd_ptr];
    assign busy        = (state != RUN) || (inflight != '0) || (fifo_count != '0);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        key_ready = 1'b0;
        case (state)
            KEYWAIT: begin
                key_ready = 1'b1;
                if (key_valid) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt <= SW'(1)) state_nxt = RUN;
            end
            RUN: begin
                in_ready = (credit_used < (CW+1)'(DEPTH));
                if (key_valid) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Old-key blocks must leave the core before the key may change.
                key_ready = (inflight == '0);
                if (key_valid && (inflight == '0)) state_nxt = SETTLE;
            end
            default: state_nxt = KEYWAIT;
        endcase
    end

    // Control, key and core-input registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= KEYWAIT;
            settle_cnt   <= '0;
            vld_pipe     <= '0;
            inflight     <= '0;
            core_key     <= '0;
            core_data_in <= '0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= (vld_pipe << 1) | LAT'(in_fire);
            if (key_fire) begin
                core_key   <= key_in;
                settle_cnt <= SW'(KEY_LAT);
            end else if ((state == SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SW'(1);
            end
            if (in_fire) core_data_in <= in_data;
            if (in_fire && !core_wr) begin
                inflight <= inflight + IW'(1);
            end else if (!in_fire && core_wr) begin
                inflight <= inflight - IW'(1);
            end
        end
    end

    // Result FIFO bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (core_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_rd) rd_ptr <= ptr_inc(rd_ptr);
            if (core_wr && !fifo_rd) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!core_wr && fifo_rd) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (core_wr) fifo_mem[wr_ptr] <= core_data_out;
    end

endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// Bench for aes_pipe_ctrl: behavioural AES-128 core model plus a scoreboard of
// expected ciphertexts, exercising key changes, back-pressure, streaming and reset.
module tb_aes_pipe_ctrl;

    localparam int LAT     = 11;
    localparam int DEPTH   = 16;
    localparam int KEY_LAT = 11;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [127:0] core_data_in;
    logic [127:0] core_key;
    logic [127:0] core_data_out;
    logic         busy;

    logic [7:0]   sbox_t [256];
    logic [127:0] core_pipe [LAT-1];
    logic [127:0] exp_q [$];
    logic [127:0] cur_key;
    int           n_vec;
    int           n_err;
    int           out_cnt;

    aes_pipe_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .KEY_LAT(KEY_LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .key_valid     (key_valid),
        .key_ready     (key_ready),
        .key_in        (key_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .core_data_in  (core_data_in),
        .core_key      (core_key),
        .core_data_out (core_data_out),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ a;
            a = xt(a);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        if (x == 8'h00) return 8'h63;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] st;
        logic [127:0] sh;
        logic [7:0]   a0, a1, a2, a3;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        st = pt ^ {w[0], w[1], w[2], w[3]};
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    sh[127-8*(r+4*c) -: 8] = sbox_t[st[127-8*(r+4*((c+r)%4)) -: 8]];
            if (rd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = sh[127-32*c -: 8];
                    a1 = sh[119-32*c -: 8];
                    a2 = sh[111-32*c -: 8];
                    a3 = sh[103-32*c -: 8];
                    sh[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                          a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                          a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                          xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
                end
            end
            st = sh ^ {w[4*rd], w[4*rd+1], w[4*rd+2], w[4*rd+3]};
        end
        return st;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) sbox_t[x] = sbox_calc(8'(x));
    end

    // Core model: result of core_data_in is presented LAT edges after it was loaded.
    always @(posedge clk) begin
        core_pipe[0] <= aes_enc(core_data_in, core_key);
        for (int i = 1; i < LAT - 1; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_data_out = core_pipe[LAT-2];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accepted input, pop and compare on accepted output.
    initial begin
        logic [127:0] exp_d;
        out_cnt = 0;
        cur_key = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("stray_out", 128'(out_valid), 128'd0);
                    end else begin
                        exp_d = exp_q.pop_front();
                        check("out_data", out_data, exp_d);
                    end
                    out_cnt++;
                end
                if (key_valid && key_ready) cur_key = key_in;
                if (in_valid && in_ready) exp_q.push_back(aes_enc(in_data, cur_key));
            end
        end
    end

    task automatic send_key(input logic [127:0] k, output int waited);
        key_valid = 1'b1;
        key_in    = k;
        waited    = 0;
        while (!key_ready && waited < 200) begin
            tick();
            waited++;
        end
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_ready(output int c);
        c = 0;
        while (!in_ready && c < 200) begin
            tick();
            c++;
        end
    endtask

    task automatic send_n(input int n, input bit rnd, input int max_cyc, output int acc, output int cyc);
        logic fire;
        acc     = 0;
        cyc     = 0;
        in_data = rnd128();
        while (acc < n && cyc < max_cyc) begin
            in_valid = 1'b1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            fire = in_ready;
            tick();
            cyc++;
            if (fire) begin
                acc++;
                in_data = rnd128();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd, input int max_cyc);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < max_cyc) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            c++;
        end
        out_ready = 1'b1;
        check("drain_left", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        int w, c, n, acc, cyc, base;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        key_valid = 1'b0;
        key_in    = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready",  128'(in_ready),  128'd0);
        check("rst_key_ready", 128'(key_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy",      128'(busy),      128'd1);
        check("rst_core_key",  core_key,        128'd0);
        check("rst_core_din",  core_data_in,    128'd0);
        rst_n = 1'b1;
        tick();

        send_key(128'h000102030405060708090a0b0c0d0e0f, w);
        check("key_wait0", 128'(w), 128'd0);
        check("settle_in_ready",  128'(in_ready),  128'd0);
        check("settle_key_ready", 128'(key_ready), 128'd0);
        check("core_key", core_key, 128'h000102030405060708090a0b0c0d0e0f);
        wait_ready(c);
        check("settle_cyc", 128'(c), 128'(KEY_LAT));

        // Single known-answer block and its latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 128'h00112233445566778899aabbccddeeff;
        n = 0;
        tick();
        n = 1;
        in_valid = 1'b0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("kat_latency", 128'(n), 128'(LAT + 1));
        check("kat_ct", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        drain(1'b0, 100);

        // Back-pressure: credits stop admission at DEPTH
        out_ready = 1'b0;
        send_n(20, 1'b0, 60, acc, cyc);
        check("fill_accepts",   128'(acc),       128'(DEPTH));
        check("full_in_ready",  128'(in_ready),  128'd0);
        check("full_out_valid", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        send_n(4, 1'b0, 100, acc, cyc);
        check("rest_accepts", 128'(acc), 128'd4);
        drain(1'b0, 200);

        // Streaming at one block per cycle
        base = out_cnt;
        send_n(30, 1'b0, 100, acc, cyc);
        check("stream_accepts", 128'(acc), 128'd30);
        check("stream_in_cyc",  128'(cyc), 128'd30);
        while (out_cnt - base < 30 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("stream_total_cyc", 128'(cyc), 128'(30 + LAT + 1));
        drain(1'b0, 50);

        // Key change with blocks in flight
        send_n(4, 1'b0, 50, acc, cyc);
        in_valid  = 1'b1;
        in_data   = rnd128();
        key_valid = 1'b1;
        key_in    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        check("keychg_in_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        check("drain_in_ready",  128'(in_ready),  128'd0);
        check("drain_key_ready", 128'(key_ready), 128'd0);
        send_key(128'h2b7e151628aed2a6abf7158809cf4f3c, w);
        check("drain_wait", 128'(w), 128'(LAT));
        wait_ready(c);
        check("settle2_cyc", 128'(c), 128'(KEY_LAT));
        send_n(5, 1'b0, 50, acc, cyc);
        drain(1'b0, 200);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send_n(10, 1'b0, 50, acc, cyc);
        repeat (4) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 128'(out_valid), 128'd0);
        check("mrst_in_ready",  128'(in_ready),  128'd0);
        check("mrst_key_ready", 128'(key_ready), 128'd1);
        check("mrst_busy",      128'(busy),      128'd1);
        check("mrst_core_key",  core_key,        128'd0);
        check("mrst_core_din",  core_data_in,    128'd0);
        exp_q.delete();
        repeat (2) tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) n++;
            tick();
        end
        check("post_rst_outs", 128'(n), 128'd0);
        send_key(128'hfeedfacecafebeef0123456789abcdef, w);
        wait_ready(c);
        check("settle3_cyc", 128'(c), 128'(KEY_LAT));

        // Random stalls across many pointer wraps
        send_n(40, 1'b1, 2000, acc, cyc);
        check("rand_accepts", 128'(acc), 128'd40);
        drain(1'b1, 2000);
        check("idle_busy", 128'(busy), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d vectors applied, required completion", n_vec);
        $fatal(1, "bench timeout");
    end

endmodule
